// File: rtl/sram_bank_pkg.sv
// Shared types, default geometry and parity helper for the sram_np_bank register-file slice.
package sram_bank_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_DEPTH       = 32;
  localparam int DEF_RD_PORTS    = 2;
  localparam int DEF_NUM_PHASES  = 10;
  localparam int DEF_READ_PHASE  = 4;
  localparam int DEF_WRITE_PHASE = 8;

  // Zero-extension to 64 bits leaves the XOR reduction unchanged for any WIDTH <= 64.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_phase_seq.sv
// Phase sequencer: emulates the adiabatic phase frame on one clock (IDLE/RUN FSM, phase, mclk, cycle_done).
module sram_phase_seq
  import sram_bank_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  output logic          busy,
  output logic [PW-1:0] phase,
  output logic          mclk,
  output logic          cycle_done
);

  localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);
  localparam int HALF = NUM_PHASES / 2;

  state_t        state;
  logic [PW-1:0] phase_nxt;

  assign phase_nxt = phase + PW'(1);
  assign busy      = (state == RUN);

  // mclk and cycle_done are computed from the upcoming phase so they stay registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      phase      <= '0;
      req_ready  <= 1'b1;
      mclk       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= RUN;
            phase      <= '0;
            req_ready  <= 1'b0;
            mclk       <= 1'b1;
            cycle_done <= 1'b0;
          end
        end
        RUN: begin
          if (phase == LAST) begin
            state      <= IDLE;
            phase      <= '0;
            req_ready  <= 1'b1;
            mclk       <= 1'b0;
            cycle_done <= 1'b0;
          end else begin
            phase      <= phase_nxt;
            mclk       <= (32'(phase_nxt) < HALF);
            cycle_done <= (phase_nxt == LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sram_np_bank.sv
// DEPTH x WIDTH register-file bank, one write port and RD_PORTS read ports, phase-sequenced transactions.
// Optional per-word even parity with per-port error flags when SRAM_NP_BANK_PARITY_EN is defined.
module sram_np_bank
  import sram_bank_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int RD_PORTS    = DEF_RD_PORTS,
  parameter int NUM_PHASES  = DEF_NUM_PHASES,
  parameter int READ_PHASE  = DEF_READ_PHASE,
  parameter int WRITE_PHASE = DEF_WRITE_PHASE,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [RD_PORTS-1:0]       rd_en,
  input  logic [RD_PORTS*AW-1:0]    rd_addr,
  output logic [RD_PORTS*WIDTH-1:0] rd_data,
  output logic                      rd_valid,
  output logic [PW-1:0]             phase,
  output logic                      mclk,
  output logic                      cycle_done
`ifdef SRAM_NP_BANK_PARITY_EN
  ,output logic [RD_PORTS-1:0]      par_err
`endif
);

  logic busy;
  logic accept;
  logic rd_hit;
  logic wr_hit;

  logic                   h_wr_en;
  logic [AW-1:0]          h_wr_addr;
  logic [WIDTH-1:0]       h_wr_data;
  logic [RD_PORTS-1:0]    h_rd_en;
  logic [RD_PORTS*AW-1:0] h_rd_addr;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] rd_word [RD_PORTS];
`ifdef SRAM_NP_BANK_PARITY_EN
  logic             par_mem [DEPTH];
  logic             rd_perr [RD_PORTS];
`endif

  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  sram_phase_seq #(.NUM_PHASES(NUM_PHASES)) u_seq (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .busy       (busy),
    .phase      (phase),
    .mclk       (mclk),
    .cycle_done (cycle_done)
  );

  assign accept = req_valid & req_ready;
  assign rd_hit = busy && (phase == PW'(READ_PHASE));
  assign wr_hit = busy && (phase == PW'(WRITE_PHASE));

  // Out-of-range reads return zero (and no parity error).
  always_comb begin
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      logic [AW-1:0] a;
      a = h_rd_addr[p*AW +: AW];
      rd_word[p] = in_range(a) ? mem[a] : '0;
`ifdef SRAM_NP_BANK_PARITY_EN
      rd_perr[p] = in_range(a) ? (even_parity(64'(mem[a])) != par_mem[a]) : 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_wr_en   <= 1'b0;
      h_wr_addr <= '0;
      h_wr_data <= '0;
      h_rd_en   <= '0;
      h_rd_addr <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
`ifdef SRAM_NP_BANK_PARITY_EN
        par_mem[i] <= 1'b0;
`endif
      end
`ifdef SRAM_NP_BANK_PARITY_EN
      par_err <= '0;
`endif
    end else begin
      if (accept) begin
        h_wr_en   <= wr_en;
        h_wr_addr <= wr_addr;
        h_wr_data <= wr_data;
        h_rd_en   <= rd_en;
        h_rd_addr <= rd_addr;
      end
      rd_valid <= rd_hit && (|h_rd_en);
      if (rd_hit) begin
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
          if (h_rd_en[p]) begin
            rd_data[p*WIDTH +: WIDTH] <= rd_word[p];
`ifdef SRAM_NP_BANK_PARITY_EN
            par_err[p] <= rd_perr[p];
`endif
          end
        end
      end
      // READ_PHASE < WRITE_PHASE gives read-before-write within one transaction.
      if (wr_hit && h_wr_en && in_range(h_wr_addr)) begin
        mem[h_wr_addr] <= h_wr_data;
`ifdef SRAM_NP_BANK_PARITY_EN
        par_mem[h_wr_addr] <= even_parity(64'(h_wr_data));
`endif
      end
    end
  end

endmodule

// File: tb/tb_sram_np_bank.sv
// Self-checking bench for sram_np_bank: a DEPTH=32 and a DEPTH=24 instance share stimulus.
module tb_sram_np_bank;

  localparam int NP = 10;
  localparam int RP = 4;
  localparam int WP = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;

  logic        req_ready_a, rd_valid_a, mclk_a, cycle_done_a;
  logic [31:0] rd_data_a;
  logic [3:0]  phase_a;
  logic        req_ready_b, rd_valid_b, mclk_b, cycle_done_b;
  logic [31:0] rd_data_b;
  logic [3:0]  phase_b;
`ifdef SRAM_NP_BANK_PARITY_EN
  logic [1:0]  par_err_a, par_err_b;
`endif

  always #5 clk = ~clk;

  sram_np_bank #(.WIDTH(16), .DEPTH(32), .RD_PORTS(2), .NUM_PHASES(NP),
                 .READ_PHASE(RP), .WRITE_PHASE(WP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .phase(phase_a), .mclk(mclk_a), .cycle_done(cycle_done_a)
`ifdef SRAM_NP_BANK_PARITY_EN
    , .par_err(par_err_a)
`endif
  );

  sram_np_bank #(.WIDTH(16), .DEPTH(24), .RD_PORTS(2), .NUM_PHASES(NP),
                 .READ_PHASE(RP), .WRITE_PHASE(WP)) dut24 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .phase(phase_b), .mclk(mclk_b), .cycle_done(cycle_done_b)
`ifdef SRAM_NP_BANK_PARITY_EN
    , .par_err(par_err_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cur_k  = 0;

  // Transaction-level reference: word arrays per instance plus last value seen on each port.
  logic [15:0] m32 [32];
  logic [15:0] m24 [32];
  logic [15:0] last32 [2];
  logic [15:0] last24 [2];
  logic [1:0]  exp_par = 2'b00;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [1:0]  re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (k=%0d): got %h, expected %h", name, cur_k, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) begin
      m32[i] = '0;
      m24[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      last32[p] = '0;
      last24[p] = '0;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " req_ready"},  {31'd0, req_ready_a}, 32'd1);
    chk({tag, " req_ready24"},{31'd0, req_ready_b}, 32'd1);
    chk({tag, " phase"},      {28'd0, phase_a},     32'd0);
    chk({tag, " mclk"},       {31'd0, mclk_a},      32'd0);
    chk({tag, " cycle_done"}, {31'd0, cycle_done_a},32'd0);
    chk({tag, " rd_valid"},   {31'd0, rd_valid_a},  32'd0);
    chk({tag, " rd_data"},    rd_data_a,            32'd0);
    chk({tag, " rd_data24"},  rd_data_b,            32'd0);
  endtask

  // Entered and left at a negedge in an idle cycle, so successive calls run back-to-back.
  task automatic do_txn(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                        input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                        input bit use_tab, input logic [15:0] t0, input logic [15:0] t1);
    logic [15:0] e32 [2];
    logic [15:0] e24 [2];
    logic [4:0]  ad  [2];
    ad[0] = a0;
    ad[1] = a1;
    for (int p = 0; p < 2; p++) begin
      e32[p] = re[p] ? m32[ad[p]] : last32[p];
      e24[p] = re[p] ? ((ad[p] < 5'd24) ? m24[ad[p]] : 16'h0000) : last24[p];
    end
    if (use_tab) begin
      e32[0] = t0;
      e32[1] = t1;
    end
    cur_k = 0;
    chk("accept req_ready",   {31'd0, req_ready_a}, 32'd1);
    chk("accept req_ready24", {31'd0, req_ready_b}, 32'd1);
    req_valid = 1'b1;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_en     = re;
    rd_addr   = {a1, a0};
    @(posedge clk);
    #1;
    // Requests during RUN must be ignored.
    wr_en   = 1'b1;
    wr_addr = 5'($urandom);
    wr_data = 16'($urandom);
    rd_en   = 2'b11;
    rd_addr = 10'($urandom);
    for (int k = 1; k <= NP + 1; k++) begin
      @(negedge clk);
      cur_k = k;
      chk("phase",      {28'd0, phase_a},      (k <= NP) ? 32'(k - 1) : 32'd0);
      chk("phase24",    {28'd0, phase_b},      (k <= NP) ? 32'(k - 1) : 32'd0);
      chk("req_ready",  {31'd0, req_ready_a},  {31'd0, k == NP + 1});
      chk("mclk",       {31'd0, mclk_a},       {31'd0, (k <= NP) && (k - 1 < NP / 2)});
      chk("cycle_done", {31'd0, cycle_done_a}, {31'd0, k == NP});
      chk("rd_valid",   {31'd0, rd_valid_a},   {31'd0, (k == RP + 2) && (re != 2'b00)});
      chk("rd_valid24", {31'd0, rd_valid_b},   {31'd0, (k == RP + 2) && (re != 2'b00)});
      if (k == RP + 1) begin
        chk("rd_data early",   rd_data_a, {last32[1], last32[0]});
        chk("rd_data24 early", rd_data_b, {last24[1], last24[0]});
      end
      if (k == RP + 2) begin
        chk("rd_data",   rd_data_a, {e32[1], e32[0]});
        chk("rd_data24", rd_data_b, {e24[1], e24[0]});
`ifdef SRAM_NP_BANK_PARITY_EN
        chk("par_err",   {30'd0, par_err_a}, {30'd0, exp_par});
        chk("par_err24", {30'd0, par_err_b}, {30'd0, exp_par});
`endif
      end
      if (k == NP) req_valid = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      last32[p] = e32[p];
      last24[p] = e24[p];
    end
    if (we) begin
      m32[wa] = wd;
      if (wa < 5'd24) m24[wa] = wd;
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_en     = '0;
    rd_addr   = '0;
    reset_model();

    tab[0] = '{1'b1, 5'd4,  16'hAAAA, 2'b00, 5'd0,  5'd0,  16'h0000, 16'h0000};
    tab[1] = '{1'b0, 5'd0,  16'h0000, 2'b11, 5'd1,  5'd4,  16'h0000, 16'hAAAA};
    tab[2] = '{1'b1, 5'd7,  16'h1234, 2'b01, 5'd7,  5'd0,  16'h0000, 16'hAAAA};
    tab[3] = '{1'b0, 5'd0,  16'h0000, 2'b11, 5'd7,  5'd7,  16'h1234, 16'h1234};
    tab[4] = '{1'b1, 5'd30, 16'hFFFF, 2'b10, 5'd0,  5'd30, 16'h1234, 16'h0000};
    tab[5] = '{1'b0, 5'd0,  16'h0000, 2'b11, 5'd30, 5'd4,  16'hFFFF, 16'hAAAA};
    tab[6] = '{1'b1, 5'd4,  16'h5555, 2'b11, 5'd4,  5'd4,  16'hAAAA, 16'hAAAA};
    tab[7] = '{1'b0, 5'd0,  16'h0000, 2'b01, 5'd4,  5'd0,  16'h5555, 16'hAAAA};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    reset = 1'b1;

    for (int i = 0; i < 16; i++)
      do_txn(1'b0, 5'd0, 16'h0, 2'b11, 5'(2 * i), 5'(2 * i + 1), 1'b1, 16'h0000, 16'h0000);

    for (int i = 0; i < 8; i++)
      do_txn(tab[i].we, tab[i].wa, tab[i].wd, tab[i].re, tab[i].a0, tab[i].a1,
             1'b1, tab[i].e0, tab[i].e1);

    for (int i = 0; i < 150; i++)
      do_txn(1'($urandom), 5'($urandom), 16'($urandom), 2'($urandom),
             5'($urandom), 5'($urandom), 1'b0, 16'h0, 16'h0);

    // Abort a write to addr 2 at phase 6 with reset.
    do_txn(1'b1, 5'd2, 16'h1111, 2'b00, 5'd0, 5'd0, 1'b0, 16'h0, 16'h0);
    req_valid = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 5'd2;
    wr_data   = 16'hBEEF;
    rd_en     = 2'b00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    cur_k = 7;
    chk("abort phase", {28'd0, phase_a}, 32'd6);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    cur_k = 0;
    chk_idle("abort");
    reset_model();
    do_txn(1'b0, 5'd0, 16'h0, 2'b11, 5'd2, 5'd2, 1'b1, 16'h0000, 16'h0000);

`ifdef SRAM_NP_BANK_PARITY_EN
    do_txn(1'b1, 5'd3, 16'h0001, 2'b00, 5'd0, 5'd0, 1'b0, 16'h0, 16'h0);
    dut.par_mem[3]   = ~dut.par_mem[3];
    dut24.par_mem[3] = ~dut24.par_mem[3];
    exp_par = 2'b01;
    do_txn(1'b0, 5'd0, 16'h0, 2'b01, 5'd3, 5'd0, 1'b0, 16'h0, 16'h0);
    exp_par = 2'b00;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_np_bank.md
Name: sram_np_bank

Overview:
- Parametrised successor to the 32x16 two-port register-file SRAM bank: DEPTH x WIDTH storage, one write port, RD_PORTS independent read ports.
- Runs its own internal phase sequencer, emulating the Bennett phase frame on a single conventional clock, so register-file timing can be verified without the multi-rail adiabatic clock.
- Sits between decode and execute. Serves operand reads (rs/rt) and result writeback in one transaction.

Parameters:
- WIDTH, 16, data bits per word
- DEPTH, 32, number of words (need not be a power of 2); AW = $clog2(DEPTH)
- RD_PORTS, 2, number of read ports (1..4)
- NUM_PHASES, 10, phases per transaction frame (>= 4)
- READ_PHASE, 4, phase index at which reads sample the array
- WRITE_PHASE, 8, phase index at which the write commits; constraint READ_PHASE < WRITE_PHASE < NUM_PHASES-1

Ports:
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-low
- req_valid  input  1  transaction request
- req_ready  output  1  bank idle, can accept a request
- wr_en  input  1  transaction includes a write
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- rd_en  input  RD_PORTS  per-port read enable
- rd_addr  input  RD_PORTS*AW  packed read addresses, port 0 in LSBs
- rd_data  output  RD_PORTS*WIDTH  packed registered read data
- rd_valid  output  1  one-cycle pulse: rd_data updated
- phase  output  PW=$clog2(NUM_PHASES)  current phase index (0 when idle)
- mclk  output  1  high during forward half-frame, phases 0..NUM_PHASES/2-1
- cycle_done  output  1  high in the final phase
- par_err  output  RD_PORTS  parity error per read port (PARITY_EN only)

Behaviour:
- Reset (reset==0 at a clk edge):
  - state IDLE; phase, rd_data, rd_valid, mclk, cycle_done, par_err all 0; req_ready 1.
  - All array words cleared to 0.
- FSM states are IDLE and RUN.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, capture wr_en, wr_addr, wr_data, rd_en and rd_addr into holding registers. Next cycle: RUN with phase = 0.
  - Inputs are ignored outside the accept cycle.
- RUN:
  - req_ready = 0; phase increments by 1 each cycle.
  - phase == READ_PHASE: each port with captured rd_en samples array[rd_addr] into rd_data. Ports with rd_en = 0 hold their previous value. rd_valid pulses in the following cycle, only if any rd_en was set.
  - phase == WRITE_PHASE: if wr_en, array[wr_addr] <= wr_data at the end of that cycle.
  - phase == NUM_PHASES-1: cycle_done = 1; next cycle returns to IDLE with phase = 0.
- Latency: request accepted at cycle T; rd_data valid at T+READ_PHASE+2; write visible to any read of the next transaction.
- Same-transaction read/write of one address is read-before-write: the read returns the old data.
- Multiple read ports at the same address all return identical data.
- Out-of-range address (>= DEPTH): write is dropped; read returns 0; no error flag.
- Back-to-back: the earliest next accept is the cycle after cycle_done. Throughput is one transaction per NUM_PHASES+1 cycles.
- Reset mid-RUN: transaction aborts. If WRITE_PHASE has not yet been reached, the write is not committed (the array is cleared by reset regardless).
- mclk is 0 in IDLE.

Optional Feature:
- Macro SRAM_NP_BANK_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, ^wr_data, written at WRITE_PHASE.
  - At READ_PHASE each enabled port recomputes parity; par_err[p] is registered alongside rd_data[p] and is 1 on mismatch.
  - Out-of-range reads give par_err 0. par_err resets to 0.
- Undefined: no par_err port and no parity storage.

Decomposition:
- Package sram_bank_pkg:
  - state enum (IDLE, RUN)
  - default constants: WIDTH 16, DEPTH 32, NUM_PHASES 10, READ_PHASE 4, WRITE_PHASE 8
  - function computing even parity
- Sub-module sram_phase_seq: FSM, phase counter, req_ready, mclk and cycle_done generation, parametrised by NUM_PHASES. The bank instantiates it and keys its array operations off phase.

Test Plan:
- Reset then read all 32 addresses on ports 0/1 -> rd_data all 0x0000, rd_valid pulses once per transaction, par_err 0.
- Write addr 4 = 0xAAAA, then next transaction reads port0 = addr 1 and port1 = addr 4 -> rd_data port0 0x0000, port1 0xAAAA; rd_valid at T+6.
- Same transaction writes addr 7 = 0x1234 and reads addr 7 -> old 0x0000; the following transaction reads 0x1234.
- DEPTH = 24: write addr 30 = 0xFFFF then read addr 30 -> 0x0000; all in-range words unchanged.
- Assert reset low at phase 6 of a write to addr 2 -> FSM goes to IDLE, addr 2 reads 0; assert req_valid during RUN -> request ignored, req_ready 0.
- PARITY_EN: write addr 3 = 0x0001, force the stored parity bit, then read -> par_err[0] = 1, rd_data 0x0001.
